// File: rtl/mhd_pkg.sv
// mhd_pkg -- shared width function and saturating-increment helper for the Hamming-distance monitor.
// Revision 1.0
`default_nettype none
package mhd_pkg;

  // Number of bits needed to hold a count from 0 to width inclusive.
  function automatic int hdw_f(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= lim) ? lim : v + 64'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mhd_popcount.sv
// mhd_popcount -- combinational population count of a WIDTH-bit vector.
// Revision 1.0
`default_nettype none
module mhd_popcount
  import mhd_pkg::*;
#(
  parameter int WIDTH = 9,
  localparam int HDW = hdw_f(WIDTH)
) (
  input  logic [WIDTH-1:0] diff,
  output logic [HDW-1:0]   count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + HDW'(diff[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/mhd_stream_monitor.sv
// mhd_stream_monitor -- two-stage Hamming-distance checker with valid/ready flow control and statistics.
// Revision 1.0
`default_nettype none
module mhd_stream_monitor
  import mhd_pkg::*;
#(
  parameter int WIDTH = 9,
  parameter int MHD   = 3,
  parameter int CNT_W = 16,
  localparam int HDW  = hdw_f(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [HDW-1:0]   hd,
  output logic             viol,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [HDW-1:0]   max_hd,
  output logic             sticky_err
);

  logic             w_adv;
  logic             w_out_hs;
  logic [HDW-1:0]   w_cnt;
  logic             w_viol;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_diff;
  logic             r_out_valid;
  logic [HDW-1:0]   r_hd;
  logic             r_viol;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_viol_cnt;
  logic [HDW-1:0]   r_max_hd;
  logic             r_sticky;

  assign w_adv    = !r_out_valid || out_ready;
  assign w_out_hs = r_out_valid && out_ready;

  mhd_popcount #(.WIDTH(WIDTH)) u_popcount (
    .diff  (r_s1_diff),
    .count (w_cnt)
  );

  // A distance can never exceed WIDTH, so such a threshold can never be crossed.
  generate
    if (MHD >= WIDTH) begin : g_viol_never
      assign w_viol = 1'b0;
    end else begin : g_viol_cmp
      assign w_viol = (w_cnt > HDW'(MHD));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_diff   <= '0;
      r_out_valid <= 1'b0;
      r_hd        <= '0;
      r_viol      <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid  <= in_valid;
      if (in_valid) begin
        r_s1_diff <= a ^ b;
      end
      r_out_valid <= r_s1_valid;
      r_hd        <= w_cnt;
      r_viol      <= w_viol;
    end
  end

  // Clear wins over a coincident output handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample_cnt <= '0;
      r_viol_cnt   <= '0;
      r_max_hd     <= '0;
      r_sticky     <= 1'b0;
    end else if (clear) begin
      r_sample_cnt <= '0;
      r_viol_cnt   <= '0;
      r_max_hd     <= '0;
      r_sticky     <= 1'b0;
    end else if (w_out_hs) begin
      r_sample_cnt <= CNT_W'(sat_inc(64'(r_sample_cnt), CNT_W));
      if (r_viol) begin
        r_viol_cnt <= CNT_W'(sat_inc(64'(r_viol_cnt), CNT_W));
        r_sticky   <= 1'b1;
      end
      if (r_hd > r_max_hd) begin
        r_max_hd <= r_hd;
      end
    end
  end

  assign in_ready   = w_adv;
  assign out_valid  = r_out_valid;
  assign hd         = r_hd;
  assign viol       = r_viol;
  assign sample_cnt = r_sample_cnt;
  assign viol_cnt   = r_viol_cnt;
  assign max_hd     = r_max_hd;
  assign sticky_err = r_sticky;

endmodule
`default_nettype wire

// File: doc/mhd_stream_monitor.md
MHD_STREAM_MONITOR -- requirements
Module: mhd_stream_monitor

Interface
REQ-001 Parameter WIDTH, default 9: operand width in bits, legal range 1..64.
REQ-002 Parameter MHD, default 3: maximum allowed Hamming distance; a sample violates when HD > MHD.
REQ-003 Parameter CNT_W, default 16: width of the statistics counters.
REQ-004 Port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port clear, input, 1: synchronous clear of statistics (REQ-019).
REQ-007 Port in_valid, input, 1: a/b pair offered.
REQ-008 Port in_ready, output, 1: monitor accepts the pair this cycle.
REQ-009 Port a, input, WIDTH: operand A.
REQ-010 Port b, input, WIDTH: operand B.
REQ-011 Port out_valid, output, 1: per-sample result presented.
REQ-012 Port out_ready, input, 1: downstream accepts the result.
REQ-013 Port hd, output, HDW = clog2(WIDTH+1): Hamming distance of the presented sample.
REQ-014 Port viol, output, 1: presented sample has hd > MHD.
REQ-015 Port sample_cnt, output, CNT_W: results accepted downstream since reset/clear.
REQ-016 Port viol_cnt, output, CNT_W: accepted results with viol=1 since reset/clear.
REQ-017 Port max_hd, output, HDW: largest hd accepted since reset/clear.
REQ-018 Port sticky_err, output, 1: set by the first accepted violation; held until clear or reset.

Function
REQ-019 Pipeline: stage 1 registers diff = a XOR b on input handshake (in_valid && in_ready); stage 2 registers hd = popcount(diff) and viol = (hd > MHD); out_valid is driven from stage 2.
REQ-020 Latency: the result for a pair accepted in cycle N is presented with out_valid=1 in cycle N+2, given no backpressure.
REQ-021 Advance condition: adv = !out_valid || out_ready; both stages move only when adv=1; in_ready = adv (combinational, no dependency on in_valid).
REQ-022 Under backpressure (out_valid=1, out_ready=0), hd, viol and out_valid SHALL hold stable, and the contents of stage 1 SHALL be retained.
REQ-023 Throughput SHALL be one sample per cycle when out_ready is held at 1; bubbles propagate as out_valid=0.
REQ-024 Statistics SHALL update only on output handshake (out_valid && out_ready):
  - sample_cnt += 1
  - viol_cnt += viol
  - max_hd = max(max_hd, hd)
  - sticky_err |= viol
REQ-025 sample_cnt and viol_cnt SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-026 Arithmetic: popcount SHALL be computed in HDW bits; the compare SHALL be unsigned with MHD extended to HDW bits; when MHD >= WIDTH, viol is constantly 0.
REQ-027 clear=1 SHALL zero all four statistics outputs at the next edge; clear has priority over a simultaneous handshake, so that sample is not counted.
REQ-028 clear SHALL NOT affect the pipeline contents or the handshake.

Reset
REQ-029 With rst_n=0, immediately and asynchronously:
  - out_valid=0, hd=0, viol=0
  - stage-1 valid=0
  - sample_cnt=0, viol_cnt=0, max_hd=0, sticky_err=0
REQ-030 Asserting reset mid-stream SHALL discard all in-flight samples without a result; the first pair accepted after release appears 2 cycles later.

Structure
REQ-031 Package mhd_pkg SHALL hold the HDW width function clog2(WIDTH+1) and the saturating-increment helper.
REQ-032 Sub-module mhd_popcount (parameter WIDTH; input diff; output count[HDW]) SHALL be combinational and instantiated in stage 2.

Verification (WIDTH=9, MHD=3, CNT_W=4)
REQ-033 a=9'h000, b=9'h00F, out_ready=1 -> two cycles later: hd=4, viol=1, then sample_cnt=1, viol_cnt=1, sticky_err=1, max_hd=4.
REQ-034 Back-to-back pairs with HD 0, 3, 9, 1 and out_ready=1 -> hd stream 0,3,9,1; viol stream 0,0,1,0; max_hd=9; viol_cnt=1.
REQ-035 out_ready=0 for 5 cycles with 2 samples in flight -> in_ready=0, hd held stable, no counter change; on release both results emerge in order.
REQ-036 20 violating samples -> viol_cnt and sample_cnt saturate at 15.
REQ-037 clear asserted in the same cycle as a violating handshake -> all statistics 0 next cycle.
REQ-038 rst_n pulsed low with 2 samples in flight -> out_valid=0 immediately; no stale result after release.
